// File: rtl/regfile_seqclr.sv
// Register file with sequenced clear: one write port, two combinational read ports, one register cleared per cycle.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding in RUN.
module regfile_seqclr #(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_W    = 3,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  BUS,
  input  logic [ADDR_W-1:0] DR,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  input  logic              CLR,
  output logic [WIDTH-1:0]  SR1_OUT,
  output logic [WIDTH-1:0]  SR2_OUT,
  output logic              READY
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  w_rd1;
  logic [WIDTH-1:0]  w_rd2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
    r_cnt   <= w_cnt_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_waddr     = DR;
    w_wdata     = BUS;
    if (rst) begin
      w_state_nxt = ST_CLEAR;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          w_we    = 1'b1;
          w_waddr = r_cnt;
          w_wdata = CLEAR_VAL;
          if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
          else                             w_cnt_nxt   = r_cnt + ADDR_W'(1);
        end
        ST_RUN: begin
          if (CLR) begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
          end else if (LD_REG) begin
            w_we = 1'b1;
          end
        end
        default: w_state_nxt = ST_CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset so it can map onto LUT RAM; the clear sequence initialises it instead.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;
  assign w_fwd = w_we && (r_state == ST_RUN);
  assign w_rd1 = (w_fwd && (DR == SR1)) ? BUS : r_mem[SR1];
  assign w_rd2 = (w_fwd && (DR == SR2)) ? BUS : r_mem[SR2];
`else
  assign w_rd1 = r_mem[SR1];
  assign w_rd2 = r_mem[SR2];
`endif

  // Contents are masked while clearing so stale or undefined data never escapes.
  assign SR1_OUT = (r_state == ST_RUN) ? w_rd1 : CLEAR_VAL;
  assign SR2_OUT = (r_state == ST_RUN) ? w_rd2 : CLEAR_VAL;
  assign READY   = (r_state == ST_RUN);

endmodule

// File: tb/tb_regfile_seqclr.sv
// Scoreboard bench for regfile_seqclr: a default 16x8 build and a 32x16 build with CLEAR_VAL=0xDEADBEEF.
module tb_regfile_seqclr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build: WIDTH=16, ADDR_W=3
  logic        a_rst = 1'b1, a_ld = 1'b0, a_clr = 1'b0;
  logic [15:0] a_bus = '0;
  logic [2:0]  a_dr = '0, a_sr1 = '0, a_sr2 = '0;
  logic [15:0] a_o1, a_o2;
  logic        a_rdy;

  // Wide build: WIDTH=32, ADDR_W=4
  logic        b_rst = 1'b0, b_ld = 1'b0, b_clr = 1'b0;
  logic [31:0] b_bus = '0;
  logic [3:0]  b_dr = '0, b_sr1 = '0, b_sr2 = '0;
  logic [31:0] b_o1, b_o2;
  logic        b_rdy;

  regfile_seqclr u_a (
    .clk(clk), .rst(a_rst), .BUS(a_bus), .DR(a_dr), .LD_REG(a_ld),
    .SR1(a_sr1), .SR2(a_sr2), .CLR(a_clr),
    .SR1_OUT(a_o1), .SR2_OUT(a_o2), .READY(a_rdy)
  );

  regfile_seqclr #(.WIDTH(32), .ADDR_W(4), .CLEAR_VAL(32'hDEAD_BEEF)) u_b (
    .clk(clk), .rst(b_rst), .BUS(b_bus), .DR(b_dr), .LD_REG(b_ld),
    .SR1(b_sr1), .SR2(b_sr2), .CLR(b_clr),
    .SR1_OUT(b_o1), .SR2_OUT(b_o2), .READY(b_rdy)
  );

  typedef enum int {A_SR1, A_SR2, A_RDY, B_SR1, B_SR2, B_RDY} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string name, input sel_t sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the outputs are combinational, so they are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        A_SR1:   act = {16'h0, a_o1};
        A_SR2:   act = {16'h0, a_o2};
        A_RDY:   act = {31'h0, a_rdy};
        B_SR1:   act = b_o1;
        B_SR2:   act = b_o2;
        default: act = {31'h0, b_rdy};
      endcase
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset then an 8-cycle clear
    a_rst = 1'b1;
    cyc();
    a_rst = 1'b0;
    a_sr1 = 3'd5;
    for (int i = 0; i < 8; i++) begin
      check("clr_ready_low", A_RDY, 32'd0);
      check("clr_masked", A_SR1, 32'd0);
      cyc();
    end
    for (int r = 0; r < 8; r++) begin
      a_sr1 = 3'(r);
      a_sr2 = 3'(7 - r);
      check("post_reset_ready", A_RDY, 32'd1);
      check("post_reset_sr1", A_SR1, 32'd0);
      check("post_reset_sr2", A_SR2, 32'd0);
      cyc();
    end

    // 2: two writes then dual read
    a_ld = 1'b1; a_dr = 3'd3; a_bus = 16'hBEEF;
    cyc();
    a_dr = 3'd5; a_bus = 16'h1234;
    cyc();
    a_ld = 1'b0; a_sr1 = 3'd3; a_sr2 = 3'd5;
    check("wr_r3", A_SR1, 32'h0000_BEEF);
    check("wr_r5", A_SR2, 32'h0000_1234);
    cyc();
    a_sr2 = 3'd3;
    check("same_addr_sr1", A_SR1, 32'h0000_BEEF);
    check("same_addr_sr2", A_SR2, 32'h0000_BEEF);
    cyc();
    for (int r = 0; r < 8; r++) begin
      if (r != 3 && r != 5) begin
        a_sr1 = 3'(r);
        check("others_zero", A_SR1, 32'd0);
        cyc();
      end
    end

    // 3: same-cycle read of the write address
    a_ld = 1'b1; a_dr = 3'd2; a_bus = 16'hA5A5; a_sr1 = 3'd2; a_sr2 = 3'd3;
    check("fwd_sr1", A_SR1, BYPASS ? 32'h0000_A5A5 : 32'd0);
    check("fwd_sr2_other", A_SR2, 32'h0000_BEEF);
    cyc();
    a_ld = 1'b0;
    check("after_write_sr1", A_SR1, 32'h0000_A5A5);
    cyc();

    // 4: write pulsed during a clear is dropped
    a_clr = 1'b1;
    cyc();
    a_clr = 1'b0; a_sr1 = 3'd3; a_sr2 = 3'd2;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        a_ld = 1'b1; a_dr = 3'd1; a_bus = 16'hFFFF; a_sr1 = 3'd1;
      end else begin
        a_ld = 1'b0; a_sr1 = 3'd3;
      end
      check("clr2_ready_low", A_RDY, 32'd0);
      check("clr2_sr1_masked", A_SR1, 32'd0);
      check("clr2_sr2_masked", A_SR2, 32'd0);
      cyc();
    end
    a_ld = 1'b0; a_sr1 = 3'd1; a_sr2 = 3'd3;
    check("clr2_ready", A_RDY, 32'd1);
    check("dropped_write_r1", A_SR1, 32'd0);
    check("cleared_r3", A_SR2, 32'd0);
    cyc();

    // 5: CLR beats LD_REG, then rst restarts the clear
    a_ld = 1'b1; a_dr = 3'd2; a_bus = 16'h1111;
    cyc();
    a_clr = 1'b1; a_dr = 3'd4; a_bus = 16'h7777; a_sr1 = 3'd4; a_sr2 = 3'd2;
    check("clr_no_fwd", A_SR1, 32'd0);
    check("pre_clr_r2", A_SR2, 32'h0000_1111);
    cyc();
    a_clr = 1'b0; a_ld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("clr3_ready_low", A_RDY, 32'd0);
      cyc();
    end
    a_rst = 1'b1;
    cyc();
    a_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("restart_ready_low", A_RDY, 32'd0);
      cyc();
    end
    check("restart_ready", A_RDY, 32'd1);
    check("clr_beat_ld_r4", A_SR1, 32'd0);
    check("cleared_r2", A_SR2, 32'd0);
    cyc();

    // 6: wide build with non-zero CLEAR_VAL
    b_rst = 1'b1;
    cyc();
    b_rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("b_clr_ready_low", B_RDY, 32'd0);
      check("b_clr_masked", B_SR1, 32'hDEAD_BEEF);
      cyc();
    end
    for (int r = 0; r < 16; r++) begin
      b_sr1 = 4'(r);
      b_sr2 = 4'(15 - r);
      check("b_ready", B_RDY, 32'd1);
      check("b_sr1_clear", B_SR1, 32'hDEAD_BEEF);
      check("b_sr2_clear", B_SR2, 32'hDEAD_BEEF);
      cyc();
    end
    b_ld = 1'b1; b_dr = 4'd15; b_bus = 32'hCAFE_F00D;
    cyc();
    b_ld = 1'b0; b_sr1 = 4'd15; b_sr2 = 4'd14;
    check("b_wr_r15", B_SR1, 32'hCAFE_F00D);
    check("b_r14_untouched", B_SR2, 32'hDEAD_BEEF);
    cyc();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL %0d expectations never compared", q.size());
      n_total += q.size();
    end
    if (n_pass == n_total) $display("PASS %0d/%0d checks passed", n_pass, n_total);
    else                   $display("FAIL %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
